// File: rtl/hgate_pkg.sv
// rtl/hgate_pkg.sv - shared register map, control bits and job FSM states for the hgate job arbiter
package hgate_pkg;

   localparam logic [7:0] HG_ADDR_OP0    = 8'h00;
   localparam logic [7:0] HG_ADDR_OP1    = 8'h04;
   localparam logic [7:0] HG_ADDR_CTRL   = 8'h10;
   localparam logic [7:0] HG_ADDR_RESULT = 8'h20;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_ABORT_BIT = 1;

   localparam logic [31:0] CTRL_START = 32'(1) << CTRL_START_BIT;
   localparam logic [31:0] CTRL_ABORT = 32'(1) << CTRL_ABORT_BIT;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_GRANT   = 4'd1,
      ST_WR0     = 4'd2,
      ST_WR1     = 4'd3,
      ST_START   = 4'd4,
      ST_WAIT_HI = 4'd5,
      ST_WAIT_LO = 4'd6,
      ST_RD_ADDR = 4'd7,
      ST_RD_CAP  = 4'd8,
      ST_ABORT   = 4'd9,
      ST_RESP    = 4'd10
   } hg_state_e;

endpackage

// File: rtl/hgate_rr_arbiter.sv
// rtl/hgate_rr_arbiter.sv - combinational round-robin picker: first request after ptr, with wrap
module hgate_rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] grant_idx,
   output logic                     any
);

   localparam int IW = $clog2(N_REQ);

   logic [IW-1:0] cand;

   // Scan ptr+1 .. ptr+N_REQ so the last winner has the lowest priority.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      cand      = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = IW'((int'(ptr) + i) % N_REQ);
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hgate_job_arbiter.sv
// rtl/hgate_job_arbiter.sv - shares one hgate MMIO port between N requesters, one job in flight
module hgate_job_arbiter
   import hgate_pkg::*;
#(
   parameter int         N_REQ       = 4,
   parameter logic [7:0] ADDR_OP0    = HG_ADDR_OP0,
   parameter logic [7:0] ADDR_OP1    = HG_ADDR_OP1,
   parameter logic [7:0] ADDR_CTRL   = HG_ADDR_CTRL,
   parameter logic [7:0] ADDR_RESULT = HG_ADDR_RESULT,
   parameter int         TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ*32-1:0]   req_op0,
   input  logic [N_REQ*32-1:0]   req_op1,
   output logic [N_REQ-1:0]      rsp_valid,
   input  logic [N_REQ-1:0]      rsp_ready,
   output logic [31:0]           rsp_data,
   output logic                  rsp_err,
   output logic                  mmio_we,
   output logic [7:0]            mmio_addr,
   output logic [31:0]           mmio_wdata,
   input  logic [31:0]           mmio_rdata,
   input  logic                  busy,
   output logic [2:0]            grant_id,
   output logic                  sched_active
);

   localparam int IW = $clog2(N_REQ);

   hg_state_e     state, state_nx;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] grant_idx;
   logic [N_REQ-1:0] arb_grant;
   logic [IW-1:0] arb_idx;
   logic          arb_any;
   logic [31:0]   sel_op0, sel_op1;
   logic [31:0]   op0_q, op1_q;
   logic [15:0]   to_cnt;
   logic          to_fire;

   hgate_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any       (arb_any)
   );

   always_comb begin
      sel_op0 = '0;
      sel_op1 = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_grant[i]) begin
            sel_op0 = req_op0[i*32 +: 32];
            sel_op1 = req_op1[i*32 +: 32];
         end
      end
   end

   // The counter saturates at the firing value, so a stalled wait never wraps.
   assign to_fire      = (to_cnt == 16'(TIMEOUT_CYC - 1));
   assign grant_id     = 3'(grant_idx);
   assign sched_active = (state != ST_IDLE);

   always_comb begin
      state_nx  = state;
      req_ready = '0;
      rsp_valid = '0;
      mmio_we   = 1'b0;
      unique case (state)
         ST_IDLE:    if (arb_any) state_nx = ST_GRANT;
         ST_GRANT: begin
            req_ready[grant_idx] = 1'b1;
            state_nx = ST_WR0;
         end
         ST_WR0: begin
            mmio_we  = 1'b1;
            state_nx = ST_WR1;
         end
         ST_WR1: begin
            mmio_we  = 1'b1;
            state_nx = ST_START;
         end
         ST_START: begin
            mmio_we  = 1'b1;
            state_nx = ST_WAIT_HI;
         end
         ST_WAIT_HI: begin
            if (busy)         state_nx = ST_WAIT_LO;
            else if (to_fire) state_nx = ST_ABORT;
         end
         ST_WAIT_LO: begin
            if (!busy)        state_nx = ST_RD_ADDR;
            else if (to_fire) state_nx = ST_ABORT;
         end
         ST_RD_ADDR: state_nx = ST_RD_CAP;
         ST_RD_CAP:  state_nx = ST_RESP;
         ST_ABORT: begin
            mmio_we  = 1'b1;
            state_nx = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid[grant_idx] = 1'b1;
            if (rsp_ready[grant_idx]) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         rr_ptr     <= IW'(N_REQ - 1);
         grant_idx  <= '0;
         op0_q      <= '0;
         op1_q      <= '0;
         to_cnt     <= '0;
         mmio_addr  <= '0;
         mmio_wdata <= '0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
      end else begin
         state <= state_nx;

         if (state == ST_IDLE && arb_any) begin
            rr_ptr    <= arb_idx;
            grant_idx <= arb_idx;
            op0_q     <= sel_op0;
            op1_q     <= sel_op1;
         end

         if (state_nx != state && (state_nx == ST_WAIT_HI || state_nx == ST_WAIT_LO))
            to_cnt <= '0;
         else if (!to_fire)
            to_cnt <= to_cnt + 16'd1;

         // Address/data are loaded on entry so they are stable for the whole state.
         case (state_nx)
            ST_WR0: begin
               mmio_addr  <= ADDR_OP0;
               mmio_wdata <= op0_q;
            end
            ST_WR1: begin
               mmio_addr  <= ADDR_OP1;
               mmio_wdata <= op1_q;
            end
            ST_START: begin
               mmio_addr  <= ADDR_CTRL;
               mmio_wdata <= CTRL_START;
            end
            ST_RD_ADDR: mmio_addr <= ADDR_RESULT;
            ST_ABORT: begin
               mmio_addr  <= ADDR_CTRL;
               mmio_wdata <= CTRL_ABORT;
            end
            default: ;
         endcase

         if (state == ST_RD_CAP) begin
            rsp_data <= mmio_rdata;
            rsp_err  <= 1'b0;
         end else if (state == ST_ABORT) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hgate_job_arbiter.sv
// tb/tb_hgate_job_arbiter.sv - scoreboard bench for hgate_job_arbiter with a behavioural core model
module tb_hgate_job_arbiter;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N*32-1:0] req_op0, req_op1;
   logic [31:0]     rsp_data, mmio_wdata, mmio_rdata;
   logic            rsp_err, mmio_we, busy, sched_active;
   logic [7:0]      mmio_addr;
   logic [2:0]      grant_id;

   always #5 clk = ~clk;

   hgate_job_arbiter #(.N_REQ(N), .TIMEOUT_CYC(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op0      (req_op0),
      .req_op1      (req_op1),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .mmio_we      (mmio_we),
      .mmio_addr    (mmio_addr),
      .mmio_wdata   (mmio_wdata),
      .mmio_rdata   (mmio_rdata),
      .busy         (busy),
      .grant_id     (grant_id),
      .sched_active (sched_active)
   );

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct packed {
      logic [2:0]  idx;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   wr_t  exp_wr[$];
   rsp_t exp_rsp[$];
   int   exp_gnt[$];

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] tab0 [N][8];
   logic [31:0] tab1 [N][8];
   int head [N];
   int tail [N];

   int   core_mode = 0;
   int   busy_len  = 3;
   int   busy_cnt  = 0;
   bit   stuck     = 1'b0;
   logic [31:0] c_op0, c_op1;
   int   cyc = 0;
   int   last_grant_cyc = 0;
   int   abort_gap = -1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic enqueue(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_d, input bit exp_e, input bit with_rsp);
      tab0[r][tail[r]] = a;
      tab1[r][tail[r]] = b;
      tail[r]++;
      exp_gnt.push_back(r);
      exp_wr.push_back({8'h00, a});
      exp_wr.push_back({8'h04, b});
      exp_wr.push_back({8'h10, 32'h1});
      if (exp_e) exp_wr.push_back({8'h10, 32'h2});
      if (with_rsp) exp_rsp.push_back({3'(r), exp_d, exp_e});
   endtask

   task automatic drain(input string name);
      int k = 0;
      while ((exp_rsp.size() != 0 || sched_active) && k < 600) begin
         tick();
         k++;
      end
      chk({name, "_completed"}, 128'(k < 600), 128'(1));
      chk({name, "_writes_seen"}, 128'(exp_wr.size()), 128'(0));
   endtask

   // Monitors, core model and requester driver, all sampled mid-cycle.
   initial begin
      int   g;
      wr_t  w;
      rsp_t r;
      req_valid  = '0;
      req_op0    = '0;
      req_op1    = '0;
      busy       = 1'b0;
      mmio_rdata = '0;
      c_op0      = '0;
      c_op1      = '0;
      forever begin
         @(negedge clk);
         cyc++;

         if (req_ready != '0) begin
            last_grant_cyc = cyc;
            if (exp_gnt.size() == 0) chk("unexpected_grant", 128'(req_ready), 128'(0));
            else begin
               g = exp_gnt.pop_front();
               chk("grant_onehot", 128'(req_ready), 128'(1) << g);
               chk("grant_id", 128'(grant_id), 128'(g));
            end
         end

         if (mmio_we) begin
            if (mmio_addr == 8'h10 && mmio_wdata == 32'h2) abort_gap = cyc - last_grant_cyc;
            if (exp_wr.size() == 0) chk("unexpected_write", 128'({mmio_addr, mmio_wdata}), 128'(0));
            else begin
               w = exp_wr.pop_front();
               chk("mmio_write", 128'({mmio_addr, mmio_wdata}), 128'(w));
            end
         end

         if ((rsp_valid & rsp_ready) != '0) begin
            if (exp_rsp.size() == 0) chk("unexpected_rsp", 128'(rsp_valid), 128'(0));
            else begin
               r = exp_rsp.pop_front();
               chk("rsp_valid_onehot", 128'(rsp_valid), 128'(1) << r.idx);
               chk("rsp_data", 128'(rsp_data), 128'(r.data));
               chk("rsp_err", 128'(rsp_err), 128'(r.err));
            end
         end

         if (!rst_n) begin
            busy_cnt = 0;
            stuck    = 1'b0;
            c_op0    = '0;
            c_op1    = '0;
         end else begin
            if (busy_cnt > 0) busy_cnt--;
            if (mmio_we) begin
               case (mmio_addr)
                  8'h00: c_op0 = mmio_wdata;
                  8'h04: c_op1 = mmio_wdata;
                  8'h10: begin
                     if (mmio_wdata == 32'h1) begin
                        if (core_mode == 0)      busy_cnt = busy_len;
                        else if (core_mode == 2) stuck = 1'b1;
                     end else if (mmio_wdata == 32'h2) begin
                        busy_cnt = 0;
                        stuck    = 1'b0;
                     end
                  end
                  default: ;
               endcase
            end
         end
         busy       = stuck || (busy_cnt > 0);
         mmio_rdata = (mmio_addr == 8'h20) ? c_op0 + c_op1 : 32'h0;

         for (int i = 0; i < N; i++) begin
            if (req_ready[i]) head[i]++;
            req_valid[i] = (head[i] < tail[i]);
            if (head[i] < tail[i]) begin
               req_op0[32*i +: 32] = tab0[i][head[i]];
               req_op1[32*i +: 32] = tab1[i][head[i]];
            end
         end
      end
   end

   initial begin
      int k;
      rst_n     = 1'b0;
      rsp_ready = '1;
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      repeat (3) @(posedge clk);
      #2;

      chk("rst_req_ready", 128'(req_ready), 128'(0));
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("rst_mmio", 128'({mmio_we, mmio_addr, mmio_wdata}), 128'(0));
      chk("rst_rsp", 128'({rsp_err, rsp_data}), 128'(0));
      chk("rst_sched", 128'({grant_id, sched_active}), 128'(0));

      rst_n = 1'b1;
      tick();

      // Round-robin from reset: 0,1,2,3 then requester 0 again.
      enqueue(0, 32'd1,    32'd2,    32'd3,    1'b0, 1'b1);
      enqueue(1, 32'd10,   32'd20,   32'd30,   1'b0, 1'b1);
      enqueue(2, 32'd100,  32'd200,  32'd300,  1'b0, 1'b1);
      enqueue(3, 32'd1000, 32'd2000, 32'd3000, 1'b0, 1'b1);
      enqueue(0, 32'd7,    32'd8,    32'd15,   1'b0, 1'b1);
      drain("rr");

      enqueue(0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1);
      drain("single");

      // Busy never rises: 16 cycles in WAIT_HI then abort.
      core_mode = 1;
      enqueue(1, 32'h11, 32'h22, 32'h0, 1'b1, 1'b1);
      drain("timeout_hi");
      chk("timeout_hi_gap", 128'(abort_gap), 128'(20));

      // Busy sticks high: 16 cycles in WAIT_LO then abort.
      core_mode = 2;
      enqueue(3, 32'd3, 32'd3, 32'h0, 1'b1, 1'b1);
      drain("timeout_lo");
      chk("timeout_lo_gap", 128'(abort_gap), 128'(21));
      chk("core_released", 128'(busy), 128'(0));

      // Response stall on requester 1; ready on other indices must be ignored.
      core_mode = 0;
      busy_len  = 2;
      rsp_ready = 4'b1101;
      enqueue(1, 32'd3, 32'd4, 32'd7,  1'b0, 1'b1);
      enqueue(2, 32'd9, 32'd9, 32'd18, 1'b0, 1'b1);
      k = 0;
      while (!rsp_valid[1] && k < 100) begin
         tick();
         k++;
      end
      chk("stall_reached", 128'(rsp_valid[1]), 128'(1));
      repeat (20) begin
         tick();
         chk("stall_hold", 128'({rsp_valid, rsp_err, rsp_data, req_ready, sched_active}),
             128'({4'b0010, 1'b0, 32'd7, 4'b0000, 1'b1}));
      end
      rsp_ready = '1;
      drain("stall");

      // Reset while the core is busy in WAIT_LO.
      busy_len = 10;
      enqueue(2, 32'd11, 32'd22, 32'h0, 1'b0, 1'b0);
      k = 0;
      while (!busy && k < 50) begin
         tick();
         k++;
      end
      chk("rst_job_busy", 128'(busy), 128'(1));
      tick();
      chk("pre_rst_state", 128'({sched_active, grant_id, mmio_addr, mmio_wdata}),
          128'({1'b1, 3'd2, 8'h10, 32'h1}));
      rst_n = 1'b0;
      #1;
      chk("midrst_handshake", 128'({req_ready, rsp_valid, rsp_err, rsp_data}), 128'(0));
      chk("midrst_mmio", 128'({mmio_we, mmio_addr, mmio_wdata}), 128'(0));
      chk("midrst_sched", 128'({grant_id, sched_active}), 128'(0));
      repeat (2) tick();
      rst_n    = 1'b1;
      busy_len = 3;
      tick();

      enqueue(0, 32'd2, 32'd2, 32'd4, 1'b0, 1'b1);
      enqueue(2, 32'd1, 32'd1, 32'd2, 1'b0, 1'b1);
      drain("post_rst");

      chk("grants_all_seen", 128'(exp_gnt.size()), 128'(0));
      chk("rsps_all_seen", 128'(exp_rsp.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
